// File: rtl/shift_sequencer.sv
// Multi-cycle controller that sequences an external single-bit shift_register
// through a load followed by `amount` single-bit shifts, then captures the result.
module shift_sequencer #(
    parameter int w  = 8,
    parameter int aw = $clog2(w) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [aw-1:0] amount,
    input  logic [w-1:0]  data,
    input  logic          clear,
    output logic          busy,
    output logic          done,
    output logic [w-1:0]  result,
    output logic          carry,
    output logic [w-1:0]  srParallelIn,
    output logic          srSerialIn,
    output logic          srLshift,
    output logic          srRshift,
    output logic          srLoad,
    output logic          srEn,
    input  logic [w-1:0]  srParallelOut,
    input  logic          srSerialOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    state_t        state;
    logic [2:0]    op_q;
    logic [aw-1:0] amount_q;
    logic [aw-1:0] count;
    logic [w-1:0]  data_q;
    logic          busy_q;
    logic          done_q;
    logic          reserved;
    logic          left;

    assign reserved = (op_q > OP_ROR);
    assign left     = (op_q == OP_LSL) || (op_q == OP_ROL);
    assign busy     = busy_q;
    assign done     = done_q;

    // busy/done are registered alongside the state so they change on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= '0;
            amount_q <= '0;
            data_q   <= '0;
            count    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
        end else if (clear) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q     <= op;
                        amount_q <= amount;
                        data_q   <= data;
                        busy_q   <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    count <= amount_q;
                    carry <= 1'b0;
                    if ((amount_q != '0) && !reserved) begin
                        state <= SHIFT;
                    end else begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                SHIFT: begin
                    carry <= srSerialOut;
                    count <= count - aw'(1);
                    if (count == aw'(1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    result <= srParallelOut;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register controls decode from state; clear gates them so the register holds
    // on the abort cycle. Rotates feed serialOut straight back into serialIn.
    always_comb begin
        srParallelIn = '0;
        srSerialIn   = 1'b0;
        srLshift     = 1'b0;
        srRshift     = 1'b0;
        srLoad       = 1'b0;
        srEn         = 1'b0;
        if (!clear) begin
            case (state)
                LOAD: begin
                    srLoad       = 1'b1;
                    srEn         = 1'b1;
                    srParallelIn = data_q;
                end
                SHIFT: begin
                    srEn     = 1'b1;
                    srLshift = left;
                    srRshift = !left;
                    case (op_q)
                        OP_ASR:         srSerialIn = srParallelOut[w-1];
                        OP_ROL, OP_ROR: srSerialIn = srSerialOut;
                        default:        srSerialIn = 1'b0;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the external shift register, applies directed
// vectors, random commands against an arithmetic reference, and control corner cases.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic [3:0] amount = '0;
    logic [7:0] data = '0;
    logic       clear = 1'b0;
    logic       busy, done, carry;
    logic [7:0] result;
    logic [7:0] srParallelIn;
    logic       srSerialIn, srLshift, srRshift, srLoad, srEn;
    logic [7:0] srParallelOut;
    logic       srSerialOut;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.w(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .amount(amount), .data(data),
        .clear(clear), .busy(busy), .done(done), .result(result), .carry(carry),
        .srParallelIn(srParallelIn), .srSerialIn(srSerialIn), .srLshift(srLshift),
        .srRshift(srRshift), .srLoad(srLoad), .srEn(srEn),
        .srParallelOut(srParallelOut), .srSerialOut(srSerialOut)
    );

    // Behavioural external shift register
    logic [7:0] sr_q = '0;
    always @(posedge clk) begin
        if (srEn) begin
            if (srLoad)        sr_q <= srParallelIn;
            else if (srLshift) sr_q <= {sr_q[6:0], srSerialIn};
            else if (srRshift) sr_q <= {srSerialIn, sr_q[7:1]};
        end
    end
    assign srParallelOut = sr_q;
    assign srSerialOut   = srLshift ? sr_q[7] : sr_q[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: returns {carry, result} computed arithmetically from the op rules
    function automatic logic [8:0] ref_model(input logic [2:0] o, input int a, input logic [7:0] d);
        int          v, sd, r, c;
        logic [15:0] t;
        v = int'(d);
        sd = d[7] ? v - 256 : v;
        r = v; c = 0;
        case (o)
            3'd0: begin r = (v << a) & 255; c = ((v << a) >> 8) & 1; end
            3'd1: begin r = v >> a; c = (a == 0) ? 0 : (v >> (a - 1)) & 1; end
            3'd2: begin r = (sd >>> a) & 255; c = (a == 0) ? 0 : (sd >>> (a - 1)) & 1; end
            3'd3: begin t = {d, d} << (a % 8); r = int'(t[15:8]); c = (a == 0) ? 0 : r & 1; end
            3'd4: begin t = {d, d} >> (a % 8); r = int'(t[7:0]); c = (a == 0) ? 0 : (r >> 7) & 1; end
            default: begin r = v; c = 0; end
        endcase
        return {c[0], r[7:0]};
    endfunction

    // Called at a negedge with the DUT idle; returns at the first idle negedge after done
    task automatic run_cmd(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d,
                           output int lat, output int bcyc, output bit sl, output bit sr,
                           output bit both);
        op = o; amount = a; data = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcyc = 0; sl = 0; sr = 0; both = 0;
        while (!done && lat < 40) begin
            if (busy) bcyc++;
            if (srLshift) sl = 1;
            if (srRshift) sr = 1;
            if (srLshift && srRshift) both = 1;
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] amt;
        logic [7:0] data;
        logic [7:0] res;
        logic       cy;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int  lat, bcyc, dcnt;
        bit  sl, sr, both;
        logic [8:0] expv;
        logic [2:0] ro;
        logic [3:0] ra;
        logic [7:0] rd;

        vecs[0] = '{3'd0, 4'd3,  8'h96, 8'hB0, 1'b0, 5};
        vecs[1] = '{3'd4, 4'd4,  8'h96, 8'h69, 1'b0, 6};
        vecs[2] = '{3'd3, 4'd1,  8'h81, 8'h03, 1'b1, 3};
        vecs[3] = '{3'd2, 4'd2,  8'h93, 8'hE4, 1'b1, 4};
        vecs[4] = '{3'd1, 4'd9,  8'h81, 8'h00, 1'b0, 11};
        vecs[5] = '{3'd0, 4'd0,  8'h5A, 8'h5A, 1'b0, 2};
        vecs[6] = '{3'd7, 4'd5,  8'h5A, 8'h5A, 1'b0, 2};
        vecs[7] = '{3'd2, 4'd12, 8'h80, 8'hFF, 1'b1, 14};
        vecs[8] = '{3'd3, 4'd9,  8'h81, 8'h03, 1'b1, 11};

        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_ctrl", {srEn, srLoad, srLshift, srRshift, srSerialIn}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_cmd(vecs[i].op, vecs[i].amt, vecs[i].data, lat, bcyc, sl, sr, both);
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
            chk($sformatf("vec%0d_carry", i), carry, vecs[i].cy);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bcyc, vecs[i].lat - 1);
            chk($sformatf("vec%0d_lshift_seen", i), sl,
                (vecs[i].amt != 0) && (vecs[i].op == 3'd0 || vecs[i].op == 3'd3));
            chk($sformatf("vec%0d_dir_exclusive", i), both, 0);
        end

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 4'($urandom_range(0, 15));
            rd = 8'($urandom);
            expv = ref_model(ro, int'(ra), rd);
            run_cmd(ro, ra, rd, lat, bcyc, sl, sr, both);
            chk($sformatf("rnd%0d_op%0d_amt%0d_d%0h_result", i, ro, ra, rd), result, expv[7:0]);
            chk($sformatf("rnd%0d_carry", i), carry, expv[8]);
            chk($sformatf("rnd%0d_latency", i), lat, (ro > 3'd4 || ra == 0) ? 2 : int'(ra) + 2);
        end

        // start during SHIFT is ignored
        op = 3'd0; amount = 4'd5; data = 8'h01; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; op = 3'd4; amount = 4'd2; data = 8'hFF;
        @(negedge clk); start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        chk("ignore_start_latency", lat, 7);
        @(negedge clk);
        chk("ignore_start_result", result, 8'h20);
        bcyc = 0;
        repeat (5) begin @(negedge clk); if (busy) bcyc++; end
        chk("ignore_start_no_extra_cmd", bcyc, 0);

        // clear mid-SHIFT aborts without done and keeps result
        op = 3'd3; amount = 4'd6; data = 8'hA5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); clear = 1'b1;
        #1;
        chk("clear_ctrl_deasserted", {srEn, srLoad, srLshift, srRshift}, 0);
        @(negedge clk); clear = 1'b0;
        chk("clear_busy", busy, 0);
        dcnt = 0;
        repeat (10) begin @(negedge clk); if (done || busy) dcnt++; end
        chk("clear_no_done", dcnt, 0);
        chk("clear_result_kept", result, 8'h20);

        // clear beats start in IDLE
        start = 1'b1; clear = 1'b1; op = 3'd0; amount = 4'd1; data = 8'h11;
        @(negedge clk); start = 1'b0; clear = 1'b0;
        chk("clear_over_start", busy, 0);
        @(negedge clk);

        // async reset mid-SHIFT
        op = 3'd0; amount = 4'd7; data = 8'h01; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #3 rst = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_result", result, 0);
        chk("async_rst_carry", carry, 0);
        chk("async_rst_ctrl", {srEn, srLoad, srLshift, srRshift, srParallelIn}, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        run_cmd(3'd0, 4'd7, 8'h01, lat, bcyc, sl, sr, both);
        chk("post_rst_result", result, 8'h80);
        chk("post_rst_carry", carry, 0);
        chk("post_rst_latency", lat, 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
